iir_ctx_sched: RTL and testbench
================================

# iir_ctx_sched

Time-division scheduler and context store that shares one leaky-integrator/2-tap-average filter step among `NCH` independent 10-bit sample channels. It holds per-channel filter state and arbitrates requesters round-robin, accepting at most one sample per cycle. It executes the filter update for the granted channel and emits a tagged, back-pressurable output stream. It sits between the per-channel ADC sample streams and downstream consumers, replacing one filter instance per channel.

## Interface
- `NCH`, 4: number of channels (≥2).
- `DW`, 10: sample/output width, signed.
- `AW`, 24: accumulator width, signed.
- `K`, 14: leak shift; output taken from bits `[K+DW-1:K]`.
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in NCH: per-channel sample request.
- `in_data` in NCH*DW: flattened samples; channel c at `[c*DW +: DW]`.
- `in_ready` out NCH: one-hot grant; a sample transfers when `in_valid[c] & in_ready[c]`.
- `clr_valid` in 1: request to zero one channel's state.
- `clr_chan` in clog2(NCH): channel to clear.
- `clr_ready` out 1: clear accepted this cycle.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts output.
- `out_chan` out clog2(NCH): channel tag of `out_data`.
- `out_data` out DW: filtered sample, signed.

## Operation
- Per-channel registers: `acc[c]` (AW), `prev[c]` (AW). Round-robin pointer `last` (index of last granted channel).
- `adv = !out_valid || out_ready` (the output slot is free or being emptied).
- Clear has priority. If `clr_valid && adv`: `clr_ready=1`, `in_ready` all 0, `acc[clr_chan]=0`, `prev[clr_chan]=0`, no output generated, `out_valid` drops if it was being consumed.
- Otherwise, if `adv`: grant goes to the first channel with `in_valid` set, searching cyclically from `last+1`. `in_ready` is one-hot for the granted channel, all 0 when none is valid. `clr_ready=0`. `in_ready` may depend combinationally on `in_valid`; requesters must not make `in_valid` depend on `in_ready`.
- If `!adv`: `in_ready=0` and `clr_ready=0`; all state and outputs hold.
- On transfer of channel c with sample x (sign-extended to AW), using pre-update values a=`acc[c]` and p=`prev[c]`:
  - `acc[c] <= a - (a >>> K) + x`, wrapping mod 2^AW with no saturation.
  - `prev[c] <= a`.
  - `out_data <= ((a + p) >>> 1)[K+DW-1:K]`. The sum is formed in AW+1 bits. `>>>` is an arithmetic floor shift.
  - `out_chan <= c`, `out_valid <= 1`, `last <= c`.
- With no transfer and `out_ready=1`: `out_valid <= 0`. `out_data` and `out_chan` hold their last values.
- Untouched channels never change state.

## Timing
- Reset (`rst` low at an edge) sets every `acc` and `prev` to 0, `out_valid=0`, `out_data=0`, `out_chan=0`, and `last=NCH-1`, so channel 0 wins first. Reset overrides any transfer or clear in the same cycle. Reset mid-stream discards the pending output.
- Latency: a sample transferred at edge t gives `out_valid=1` from t+1 with matching `out_chan`. `out_data` reflects state before that sample (one-sample group delay, as in the unshared filter).
- Throughput: one sample per cycle while `out_ready=1`. The same channel may be granted on consecutive cycles if it is the only requester.
- Stall: `out_valid && !out_ready` freezes `out_*`, `in_ready`, `clr_ready`, and all state.
- A clear and a same-channel sample in one cycle: the clear wins, and the sample waits with `in_valid` held.

## Test plan
- Round-robin: after reset, `in_valid=4'b1111` and `out_ready=1` continuously. Grants go 0,1,2,3,0,… one per cycle, and `out_chan` shows the same sequence delayed by 1 cycle.
- Step convergence: channel 1 only, x=+511 repeated. `acc[1]` reaches exactly 8372224 and stays there, `out_data` settles at 511. x=-512 from zero gives `acc` settling at -8372225 and `out_data` at -512. Other channels' outputs stay 0.
- Back-pressure: with traffic flowing, hold `out_ready=0` for 5 cycles. `in_ready=0` throughout, and `out_data`/`out_chan` are stable. Release gives resumption with the next round-robin channel, and no sample is lost or duplicated.
- Clear collision: channel 2 at steady state (x=511), `clr_valid=1` with `clr_chan=2` in the same cycle as `in_valid[2]`. Expect `clr_ready=1` and `in_ready=0` that cycle. The next two channel-2 outputs are 0 and 0 (state restarted from zero).
- Reset mid-operation: pull `rst` low for one edge during 4-channel traffic with a stalled output. Next cycle `out_valid=0`, all states 0, and the first grant goes to channel 0.
- Channel isolation: channel 0 gets x=+300 and channel 3 gets x=-300 interleaved. Each output trajectory matches a single-channel reference model bit-exactly.

Source files
------------

// File: rtl/iir_ctx_sched.sv
// Time-shared leaky-integrator / 2-tap-average filter for NCH sample channels.
// Per-channel state lives in small register arrays; one update runs per cycle.
module iir_ctx_sched #(
  parameter int NCH = 4,
  parameter int DW  = 10,
  parameter int AW  = 24,
  parameter int K   = 14,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*DW-1:0]    in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 clr_valid,
  input  logic [CW-1:0]        clr_chan,
  output logic                 clr_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_chan,
  output logic signed [DW-1:0] out_data
);

  logic signed [AW-1:0] acc  [NCH];
  logic signed [AW-1:0] prev [NCH];
  logic [CW-1:0]        last;

  logic                 adv;
  logic                 do_clr;
  logic                 do_xfer;
  logic                 found;
  logic [CW-1:0]        gidx;
  logic [CW-1:0]        cand;

  logic signed [DW-1:0] x;
  logic signed [AW-1:0] a_sel;
  logic signed [AW-1:0] p_sel;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW:0]   sum;
  logic signed [AW:0]   sum_sh;
  logic signed [DW-1:0] y;
  logic                 unused_sum_hi;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = CW'((int'(last) + i) % NCH);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_comb begin
    adv       = !out_valid || out_ready;
    do_clr    = adv && clr_valid;
    do_xfer   = adv && !clr_valid && found;
    clr_ready = do_clr;
    in_ready  = '0;
    if (do_xfer) begin
      in_ready[gidx] = 1'b1;
    end
  end

  // Filter step for the granted channel; output is the 2-tap average of acc
  always_comb begin
    a_sel   = acc[gidx];
    p_sel   = prev[gidx];
    x       = in_data[int'(gidx)*DW +: DW];
    x_ext   = {{(AW-DW){x[DW-1]}}, x};
    acc_nxt = a_sel - (a_sel >>> K) + x_ext;
    sum     = {a_sel[AW-1], a_sel} + {p_sel[AW-1], p_sel};
    sum_sh  = sum >>> (K + 1);
    y       = sum_sh[DW-1:0];
    unused_sum_hi = ^sum_sh[AW:DW];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        acc[c]  <= '0;
        prev[c] <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= CW'(NCH - 1);
    end else begin
      if (do_clr) begin
        acc[clr_chan]  <= '0;
        prev[clr_chan] <= '0;
      end
      if (do_xfer) begin
        acc[gidx]  <= acc_nxt;
        prev[gidx] <= a_sel;
        out_data   <= y;
        out_chan   <= gidx;
        out_valid  <= 1'b1;
        last       <= gidx;
      end else if (adv) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iir_ctx_sched.sv
// Directed bench for iir_ctx_sched: arbitration, filter trajectory, stall, clear, reset.
// Expected outputs come from a per-channel reference model using floor division.
module tb_iir_ctx_sched;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        in_valid;
  logic [39:0]       in_data;
  logic [3:0]        in_ready;
  logic              clr_valid;
  logic [1:0]        clr_chan;
  logic              clr_ready;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_chan;
  logic signed [9:0] out_data;

  logic signed [9:0] samp [4];

  int     checks   = 0;
  int     failures = 0;
  longint m_acc  [4];
  longint m_prev [4];
  logic   e_valid = 1'b0;
  logic [1:0] e_chan = 2'd0;
  longint e_data = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < 4; c++) in_data[c*10 +: 10] = samp[c];
  end

  iir_ctx_sched #(.NCH(4), .DW(10), .AW(24), .K(14)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .clr_valid(clr_valid), .clr_chan(clr_chan), .clr_ready(clr_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_data(out_data)
  );

  function automatic longint floorDiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint wrapAcc(input longint v);
    longint m;
    longint r;
    m = 64'sd16777216;
    r = v % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  task automatic modelStep(input int c, input longint xv, output longint yv);
    longint a;
    longint p;
    a = m_acc[c];
    p = m_prev[c];
    yv = floorDiv(a + p, 32768);
    m_prev[c] = a;
    m_acc[c]  = wrapAcc(a - floorDiv(a, 16384) + xv);
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic cv,
                               input logic [1:0] cc, input logic ordy);
    in_valid  = v;
    clr_valid = cv;
    clr_chan  = cc;
    out_ready = ordy;
  endtask

  // One clock: check grants before the edge, advance the model, check outputs after
  task automatic runCycle(input string tag, input logic [3:0] exp_rdy, input logic exp_clr);
    longint yv;
    #1;
    checkOutput({tag, "/in_ready"}, in_ready, exp_rdy);
    checkOutput({tag, "/clr_ready"}, clr_ready, exp_clr);
    if (exp_clr) begin
      m_acc[clr_chan]  = 0;
      m_prev[clr_chan] = 0;
      e_valid = 1'b0;
    end else if (exp_rdy != 4'b0000) begin
      for (int c = 0; c < 4; c++) begin
        if (exp_rdy[c]) begin
          modelStep(c, samp[c], yv);
          e_data = yv;
          e_chan = 2'(c);
        end
      end
      e_valid = 1'b1;
    end else if (out_ready) begin
      e_valid = 1'b0;
    end
    @(posedge clk); #1;
    checkOutput({tag, "/out_valid"}, out_valid, e_valid);
    checkOutput({tag, "/out_chan"}, out_chan, e_chan);
    checkOutput({tag, "/out_data"}, out_data, e_data);
  endtask

  task automatic doReset(input string tag);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      m_acc[c]  = 0;
      m_prev[c] = 0;
    end
    e_valid = 1'b0;
    e_chan  = 2'd0;
    e_data  = 0;
    checkOutput({tag, "/out_valid"}, out_valid, e_valid);
    checkOutput({tag, "/out_chan"}, out_chan, e_chan);
    checkOutput({tag, "/out_data"}, out_data, e_data);
    rst = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) samp[c] = '0;
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1);
    doReset("reset");
    runCycle("idle", 4'b0000, 1'b0);

    // round robin with all channels requesting
    samp[0] = 10'sd123;
    samp[1] = -10'sd77;
    samp[2] = 10'sd511;
    samp[3] = -10'sd512;
    applyStimulus(4'b1111, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) runCycle("rr", 4'(4'b0001 << (i % 4)), 1'b0);

    // back-pressure for five cycles, then resume with channel 0
    applyStimulus(4'b1111, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) runCycle("bp_stall", 4'b0000, 1'b0);
    applyStimulus(4'b1111, 1'b0, 2'd0, 1'b1);
    runCycle("bp_rel0", 4'b0001, 1'b0);
    runCycle("bp_rel1", 4'b0010, 1'b0);
    runCycle("bp_rel2", 4'b0100, 1'b0);
    runCycle("bp_rel3", 4'b1000, 1'b0);

    // idle clears of channels 1 and 2
    applyStimulus(4'b0000, 1'b1, 2'd1, 1'b1);
    runCycle("clr1", 4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1, 2'd2, 1'b1);
    runCycle("clr2", 4'b0000, 1'b1);

    // positive step on channel 1: first nonzero output (1) on the 34th sample
    samp[1] = 10'sd511;
    applyStimulus(4'b0010, 1'b0, 2'd0, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      runCycle("step_pos", 4'b0010, 1'b0);
      if (i == 33) checkOutput("step_pos_n33", out_data, 0);
      if (i == 34) checkOutput("step_pos_n34", out_data, 1);
    end

    // negative step from zero: floor shift gives -1 on the second output
    applyStimulus(4'b0000, 1'b1, 2'd1, 1'b1);
    runCycle("clr1b", 4'b0000, 1'b1);
    samp[1] = -10'sd512;
    applyStimulus(4'b0010, 1'b0, 2'd0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      runCycle("step_neg", 4'b0010, 1'b0);
      if (i == 1) checkOutput("step_neg_n1", out_data, 0);
      if (i == 2) checkOutput("step_neg_n2", out_data, -1);
    end

    // clear colliding with a channel-2 sample
    samp[2] = 10'sd511;
    applyStimulus(4'b0100, 1'b0, 2'd0, 1'b1);
    for (int i = 1; i <= 34; i++) runCycle("ch2_fill", 4'b0100, 1'b0);
    checkOutput("ch2_pre_clr", out_data, 1);
    applyStimulus(4'b0100, 1'b1, 2'd2, 1'b1);
    runCycle("clr_coll", 4'b0000, 1'b1);
    applyStimulus(4'b0100, 1'b0, 2'd0, 1'b1);
    runCycle("post_clr", 4'b0100, 1'b0);
    checkOutput("post_clr_1", out_data, 0);
    runCycle("post_clr", 4'b0100, 1'b0);
    checkOutput("post_clr_2", out_data, 0);

    // channels 0 and 3 interleaved with opposite-sign inputs
    samp[0] = 10'sd300;
    samp[3] = -10'sd300;
    applyStimulus(4'b1001, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 120; i++) runCycle("iso", (i % 2 == 0) ? 4'b1000 : 4'b0001, 1'b0);

    // reset while the output is stalled under full traffic
    applyStimulus(4'b1111, 1'b0, 2'd0, 1'b1);
    runCycle("pre_rst", 4'b0010, 1'b0);
    applyStimulus(4'b1111, 1'b0, 2'd0, 1'b0);
    runCycle("rst_stall", 4'b0000, 1'b0);
    doReset("rst_mid");
    applyStimulus(4'b1111, 1'b0, 2'd0, 1'b1);
    runCycle("post_rst0", 4'b0001, 1'b0);
    checkOutput("post_rst_ch0", out_data, 0);
    runCycle("post_rst1", 4'b0010, 1'b0);
    runCycle("post_rst2", 4'b0100, 1'b0);
    runCycle("post_rst3", 4'b1000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
